extract_sched: RTL and testbench
================================

EXTRACT_SCHED -- requirements
Module: extract_sched

Interface
REQ-001 Parameter FRAME_NIB, default 15, SHALL set the number of 4-bit symbols per traceback frame (15 gives a 60-bit frame, 30 gives a 120-bit frame).
REQ-002 Parameter FRAME_W, default 4*FRAME_NIB, SHALL set the frame width in bits; no other value is legal.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 i_frame  in  FRAME_W  decoded traceback frame, MSB first.
REQ-006 i_frame_valid  in  1  i_frame is valid.
REQ-007 o_frame_ready  out  1  the block can accept a frame this cycle.
REQ-008 i_abort  in  1  synchronous flush of all buffered and in-flight data.
REQ-009 o_sym  out  4  current radix-4 output symbol.
REQ-010 o_sym_valid  out  1  o_sym is valid.
REQ-011 i_sym_ready  in  1  downstream accepts o_sym.
REQ-012 o_frame_done  out  1  one-cycle pulse when the last symbol of a frame is accepted.
REQ-013 o_busy  out  1  high whenever a frame is buffered or being emitted.

Function
REQ-014 A frame SHALL be accepted in any cycle with i_frame_valid=1 and o_frame_ready=1; that is a "push".
REQ-015 A symbol SHALL be transferred in any cycle with o_sym_valid=1 and i_sym_ready=1; that is a "pop".
REQ-016 The block SHALL hold up to 2 frames in a 2-entry FIFO; occupancy SHALL be 0, 1 or 2.
REQ-017 o_frame_ready SHALL be 1 exactly when occupancy < 2, derived combinationally from registered occupancy only.
REQ-018 o_frame_ready SHALL NOT depend on a same-cycle pop, so there is no full-buffer bypass.
REQ-019 The FSM SHALL have two states.
  - IDLE: occupancy 0; o_sym_valid=0.
  - RUN: occupancy >= 1; emitting the head frame.
REQ-020 IDLE SHALL go to RUN on a push; RUN SHALL go to IDLE on the pop of the last symbol when occupancy is 1 and there is no simultaneous push.
REQ-021 Symbol index k SHALL run from 0 to FRAME_NIB-1 and increment only on a pop.
  - o_sym = head[FRAME_W-1-4k -: 4], i.e. MSB nibble first.
  - o_sym SHALL be driven from registered state.
REQ-022 Latency: a push into an empty block at cycle N SHALL give o_sym_valid=1 with symbol 0 at cycle N+1.
REQ-023 Backpressure: while o_sym_valid=1 and i_sym_ready=0, o_sym and k SHALL hold stable.
REQ-024 On the pop with k=FRAME_NIB-1, the block SHALL:
  - pulse o_frame_done for that cycle;
  - pop the head entry;
  - reset k to 0;
  - if occupancy remains >= 1, present the next frame's symbol 0 in the following cycle with no bubble.
REQ-025 A simultaneous push and last-symbol pop SHALL change occupancy by 0; with occupancy 1 the block SHALL stay in RUN.
REQ-026 Frames SHALL be emitted in push order; the FIFO write and read pointers SHALL wrap modulo 2.
REQ-027 i_abort=1 SHALL, next cycle, set occupancy=0, k=0, state=IDLE, o_sym_valid=0, o_frame_done=0.
  - Any push in the same cycle SHALL be discarded.
  - i_abort SHALL take precedence over push and pop.
REQ-028 o_busy SHALL equal (state==RUN).

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL set state=IDLE, occupancy=0, k=0, pointers=0, o_sym=0, o_sym_valid=0, o_frame_done=0 and o_busy=0.
REQ-030 o_frame_ready SHALL read 0 while rst=1.
REQ-031 A reset asserted mid-frame SHALL discard all data, and no o_frame_done SHALL be generated for that frame.
REQ-032 rst SHALL take precedence over i_abort.

Structure
REQ-033 Package extract_pkg SHALL hold NIB_W=4, the FRAME_NIB default and the FSM state enum {IDLE, RUN}.
REQ-034 The 2-entry frame storage SHALL be the sub-module frame_buf2.
  - Ports: push, pop, din, head, occupancy.
  - extract_sched SHALL contain only the FSM, the k counter and the output muxing.

Verification
REQ-035 Push frame 0x123456789ABCDEF with i_sym_ready=1 -> o_sym = 1,2,...,F on 15 consecutive cycles starting 1 cycle after the push; o_frame_done pulses on the F cycle.
REQ-036 Push frames A and B back-to-back, i_sym_ready=1 -> 30 symbols with no gap; o_frame_ready=0 while occupancy=2.
REQ-037 Toggle i_sym_ready 1/0 each cycle during a frame -> each symbol is held while ready=0; 15 pops total; o_frame_done pulses once.
REQ-038 Occupancy 1 at k=14; push and last pop in the same cycle -> o_frame_done=1; the next cycle shows the new frame's symbol 0 and state stays RUN.
REQ-039 Assert i_abort at k=7 with occupancy 2 -> next cycle o_sym_valid=0, o_busy=0, o_frame_ready=1; no o_frame_done.
REQ-040 Assert rst at k=3 for 1 cycle -> all outputs are 0 the following cycle; a new push restarts at symbol 0.

Source files
------------

// File: rtl/extract_pkg.sv
// Shared constants and FSM state type for the traceback symbol extractor.
package extract_pkg;

    localparam int NIB_W         = 4;
    localparam int FRAME_NIB_DEF = 15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/extract_sched_if.sv
// Frame-in / symbol-out handshake bundle for extract_sched.
interface extract_sched_if
    import extract_pkg::*;
#(
    parameter int FRAME_W = NIB_W * FRAME_NIB_DEF
);

    logic [FRAME_W-1:0] i_frame;
    logic               i_frame_valid;
    logic               o_frame_ready;
    logic               i_abort;
    logic [NIB_W-1:0]   o_sym;
    logic               o_sym_valid;
    logic               i_sym_ready;
    logic               o_frame_done;
    logic               o_busy;

    modport slave (
        input  i_frame, i_frame_valid, i_abort, i_sym_ready,
        output o_frame_ready, o_sym, o_sym_valid, o_frame_done, o_busy
    );

    modport master (
        output i_frame, i_frame_valid, i_abort, i_sym_ready,
        input  o_frame_ready, o_sym, o_sym_valid, o_frame_done, o_busy
    );

endinterface

// File: rtl/extract_sched_frame_buf2.sv
// Two-entry frame FIFO; head is the oldest frame, pointers wrap modulo 2.
module frame_buf2 #(
    parameter int FRAME_W = 60
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] din,
    output logic [FRAME_W-1:0] head,
    output logic [1:0]         occupancy
);

    logic [FRAME_W-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               wr_ptr_d;
    logic               rd_ptr_q;
    logic               rd_ptr_d;
    logic [1:0]         occ_q;
    logic [1:0]         occ_d;
    logic               do_push_s;
    logic               do_pop_s;

    // Writes into a full buffer and reads from an empty one are ignored.
    assign do_push_s = push && (occ_q != 2'd2);
    assign do_pop_s  = pop  && (occ_q != 2'd0);

    // Next pointer and occupancy values from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage, pointer and occupancy registers; rst also serves as flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/extract_sched.sv
// Splits buffered traceback frames into radix-4 symbols, MSB nibble first.
module extract_sched
    import extract_pkg::*;
#(
    parameter int FRAME_NIB = FRAME_NIB_DEF,
    parameter int FRAME_W   = NIB_W * FRAME_NIB
)(
    input  logic          clk,
    input  logic          rst,
    extract_sched_if.slave bus
);

    localparam int             K_W    = (FRAME_NIB > 1) ? $clog2(FRAME_NIB) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(FRAME_NIB - 1);

    state_e             state_q;
    state_e             state_d;
    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     k_d;
    logic [FRAME_W-1:0] head_s;
    logic [FRAME_W-1:0] shifted_s;
    logic [1:0]         occ_s;
    logic               ready_s;
    logic               push_s;
    logic               pop_s;
    logic               last_pop_s;
    logic               buf_clr_s;
    logic               sym_valid_s;
    logic [NIB_W-1:0]   sym_s;

    // Ready looks only at stored occupancy so a full buffer never bypasses.
    assign sym_valid_s = (state_q == RUN);
    assign ready_s     = !rst && (occ_s < 2'd2);
    assign push_s      = bus.i_frame_valid && ready_s && !bus.i_abort;
    assign pop_s       = sym_valid_s && bus.i_sym_ready && !bus.i_abort && !rst;
    assign last_pop_s  = pop_s && (k_q == LAST_K);
    assign buf_clr_s   = rst || bus.i_abort;

    frame_buf2 #(
        .FRAME_W (FRAME_W)
    ) u_buf (
        .clk       (clk),
        .rst       (buf_clr_s),
        .push      (push_s),
        .pop       (last_pop_s),
        .din       (bus.i_frame),
        .head      (head_s),
        .occupancy (occ_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave RUN only when the final frame drains with no refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                end else if (last_pop_s && (occ_s == 2'd1) && !push_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Symbol index advances on each pop and restarts at every frame boundary.
    always_comb begin
        k_d = k_q;
        if (bus.i_abort) begin
            k_d = '0;
        end else if (last_pop_s) begin
            k_d = '0;
        end else if (pop_s) begin
            k_d = k_q + K_W'(1);
        end else begin
            k_d = k_q;
        end
    end

    // Symbol index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    // Bring nibble k to the top of the frame; output forced to zero when idle.
    always_comb begin
        shifted_s = head_s << {k_q, 2'b00};
        if (sym_valid_s) begin
            sym_s = shifted_s[FRAME_W-1 -: NIB_W];
        end else begin
            sym_s = 4'h0;
        end
    end

    assign bus.o_frame_ready = ready_s;
    assign bus.o_sym         = sym_s;
    assign bus.o_sym_valid   = sym_valid_s;
    assign bus.o_frame_done  = last_pop_s;
    assign bus.o_busy        = sym_valid_s;

endmodule

// File: tb/tb_extract_sched.sv
// Self-checking bench for extract_sched: queue-based model plus directed cases.
module tb_extract_sched;

    localparam int NIB = extract_pkg::FRAME_NIB_DEF;
    localparam int FW  = 4 * NIB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    extract_sched_if #(.FRAME_W(FW)) bus ();

    extract_sched #(
        .FRAME_NIB (NIB),
        .FRAME_W   (FW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [FW-1:0] mq [$];
    int            mk = 0;
    int            total = 0;
    int            bad = 0;
    bit            check_en = 1'b0;

    logic [3:0] s_sym;
    logic       s_valid;
    logic       s_ready;
    logic       s_done;
    logic       s_busy;

    function automatic logic [3:0] nib_of(logic [FW-1:0] f, int k);
        logic [FW-1:0] t;
        t = f >> (4 * (NIB - 1 - k));
        return t[3:0];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: sample and compare at negedge, then advance the model at posedge.
    task automatic cycle();
        logic       er;
        logic       ev;
        logic       ed;
        logic [3:0] es;
        bit         pushed;
        bit         popped;
        @(negedge clk);
        s_sym   = bus.o_sym;
        s_valid = bus.o_sym_valid;
        s_ready = bus.o_frame_ready;
        s_done  = bus.o_frame_done;
        s_busy  = bus.o_busy;
        if (check_en) begin
            er = !rst && (mq.size() < 2);
            ev = (mq.size() > 0);
            es = ev ? nib_of(mq[0], mk) : 4'h0;
            ed = ev && bus.i_sym_ready && !bus.i_abort && !rst && (mk == NIB - 1);
            chk("ready", 64'(s_ready), 64'(er));
            chk("valid", 64'(s_valid), 64'(ev));
            chk("busy",  64'(s_busy),  64'(ev));
            chk("sym",   64'(s_sym),   64'(es));
            chk("done",  64'(s_done),  64'(ed));
        end
        @(posedge clk);
        if (rst || bus.i_abort) begin
            mq.delete();
            mk = 0;
        end else begin
            pushed = bus.i_frame_valid && (mq.size() < 2);
            popped = (mq.size() > 0) && bus.i_sym_ready;
            if (popped) begin
                if (mk == NIB - 1) begin
                    mq.delete(0);
                    mk = 0;
                end else begin
                    mk++;
                end
            end
            if (pushed) mq.push_back(bus.i_frame);
        end
        if (rst) check_en = 1'b1;
        #1;
    endtask

    initial begin
        logic [FW-1:0] f0;
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        logic [FW-1:0] fd;
        logic [63:0]   r64;
        int            nv;
        int            nd;
        int            np;

        f0 = 60'h123456789ABCDEF;
        fa = 60'hFEDCBA987654321;
        fb = 60'h0F1E2D3C4B5A697;
        fd = 60'h9876543210FEDCB;

        bus.i_frame       = '0;
        bus.i_frame_valid = 1'b0;
        bus.i_abort       = 1'b0;
        bus.i_sym_ready   = 1'b0;

        // reset behaviour
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_ready", 64'(s_ready), 64'(0));
        chk("rst_valid", 64'(s_valid), 64'(0));
        chk("rst_sym",   64'(s_sym),   64'(0));
        chk("rst_busy",  64'(s_busy),  64'(0));
        chk("rst_done",  64'(s_done),  64'(0));
        rst = 1'b0;
        cycle();
        chk("idle_ready", 64'(s_ready), 64'(1));

        // single frame, symbols 1..F, done on the last
        bus.i_frame = f0; bus.i_frame_valid = 1'b1; bus.i_sym_ready = 1'b1;
        cycle();
        bus.i_frame_valid = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            cycle();
            chk("f0_sym",  64'(s_sym),  64'(i + 1));
            chk("f0_done", 64'(s_done), 64'(i == NIB - 1));
        end
        cycle();
        chk("f0_after_valid", 64'(s_valid), 64'(0));

        // back-to-back frames, no gap
        nv = 0; nd = 0;
        bus.i_frame = fa; bus.i_frame_valid = 1'b1;
        cycle();
        bus.i_frame = fb;
        cycle();
        chk("b2b_first_sym", 64'(s_sym), 64'(4'hF));
        if (s_valid) nv++;
        if (s_done) nd++;
        bus.i_frame_valid = 1'b0;
        cycle();
        chk("b2b_full_ready", 64'(s_ready), 64'(0));
        if (s_valid) nv++;
        if (s_done) nd++;
        for (int i = 0; i < 2 * NIB - 2; i++) begin
            cycle();
            if (s_valid) nv++;
            if (s_done) nd++;
        end
        chk("b2b_valid_cycles", 64'(nv), 64'(2 * NIB));
        chk("b2b_done_count",   64'(nd), 64'(2));
        cycle();
        chk("b2b_idle", 64'(s_valid), 64'(0));

        // toggled downstream ready
        bus.i_frame = f0; bus.i_frame_valid = 1'b1; bus.i_sym_ready = 1'b0;
        cycle();
        bus.i_frame_valid = 1'b0;
        np = 0; nd = 0;
        for (int i = 0; i < 40 && nd == 0; i++) begin
            bus.i_sym_ready = ((i % 2) == 0);
            cycle();
            if (s_valid && bus.i_sym_ready) np++;
            if (s_done) nd++;
        end
        chk("tog_pops", 64'(np), 64'(NIB));
        chk("tog_done", 64'(nd), 64'(1));
        bus.i_sym_ready = 1'b1;
        cycle();
        chk("tog_idle", 64'(s_valid), 64'(0));

        // push coinciding with last pop at occupancy 1
        bus.i_frame = f0; bus.i_frame_valid = 1'b1;
        cycle();
        bus.i_frame_valid = 1'b0;
        for (int i = 0; i < NIB - 1; i++) cycle();
        bus.i_frame = fd; bus.i_frame_valid = 1'b1;
        cycle();
        chk("sim_done", 64'(s_done), 64'(1));
        bus.i_frame_valid = 1'b0;
        cycle();
        chk("sim_sym0", 64'(s_sym),  64'(4'h9));
        chk("sim_busy", 64'(s_busy), 64'(1));
        for (int i = 0; i < NIB; i++) cycle();

        // abort at k=7 with two frames held
        bus.i_frame = fa; bus.i_frame_valid = 1'b1;
        cycle();
        bus.i_frame = fb;
        cycle();
        bus.i_frame_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        bus.i_abort = 1'b1; bus.i_frame = fd; bus.i_frame_valid = 1'b1;
        cycle();
        bus.i_abort = 1'b0; bus.i_frame_valid = 1'b0;
        cycle();
        chk("abort_valid", 64'(s_valid), 64'(0));
        chk("abort_busy",  64'(s_busy),  64'(0));
        chk("abort_ready", 64'(s_ready), 64'(1));
        chk("abort_done",  64'(s_done),  64'(0));
        // a push in the abort cycle is discarded
        bus.i_abort = 1'b1; bus.i_frame = f0; bus.i_frame_valid = 1'b1;
        cycle();
        bus.i_abort = 1'b0; bus.i_frame_valid = 1'b0;
        cycle();
        chk("abort_discard", 64'(s_valid), 64'(0));

        // reset at k=3
        bus.i_frame = f0; bus.i_frame_valid = 1'b1;
        cycle();
        bus.i_frame_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst2_valid", 64'(s_valid), 64'(0));
        chk("rst2_sym",   64'(s_sym),   64'(0));
        chk("rst2_done",  64'(s_done),  64'(0));
        chk("rst2_busy",  64'(s_busy),  64'(0));
        bus.i_frame = fd; bus.i_frame_valid = 1'b1;
        cycle();
        bus.i_frame_valid = 1'b0;
        cycle();
        chk("rst2_restart_sym0", 64'(s_sym), 64'(4'h9));
        for (int i = 0; i < NIB; i++) cycle();

        // randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            r64 = {$urandom(), $urandom()};
            bus.i_frame       = r64[FW-1:0];
            bus.i_frame_valid = ($urandom_range(0, 1) == 1);
            bus.i_sym_ready   = ($urandom_range(0, 3) != 0);
            bus.i_abort       = ($urandom_range(0, 63) == 0);
            rst               = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; bus.i_abort = 1'b0; bus.i_frame_valid = 1'b0; bus.i_sym_ready = 1'b1;
        for (int i = 0; i < 2 * NIB + 2; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
